fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_queue.sv | 81 ++++++++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int          ILEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; redirect targets drop the low byte-offset bits.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue: wrapping head/tail pointers, occupancy count, flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_s, push_s;

    // Next-state for pointers, count and storage; flush discards everything.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_s   = pop && (count_q != CNT_ZERO);
        push_s  = push && ((count_q != CNT_FULL) || pop_s);
        if (flush) begin
            head_d  = PTR_W'(0);
            tail_d  = PTR_W'(0);
            count_d = CNT_ZERO;
        end else begin
            if (push_s) begin
                mem_d[tail_q] = push_data;
                tail_d        = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= PTR_W'(0);
            tail_q  <= PTR_W'(0);
            count_q <= CNT_ZERO;
            mem_q   <= '{default: fetch_entry_t'(64'h0)};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC sequencing, redirect flush and a decoupling queue to decode.
// Optional macro FETCH_BYPASS_EN lets a fetch reach decode in its own cycle when the queue is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int               CNT_W    = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FQ_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_s;
    fetch_entry_t     head_s, fetch_s, out_entry_s;
    logic             live_s, flush_s, q_empty_s, bypass_s;
    logic             out_valid_s, q_pop_s, room_s, advance_s, push_s;

    // Fetch/deliver decisions; reset beats redirect, redirect beats any handshake.
    always_comb begin
        fetch_s.pc    = pc_q;
        fetch_s.instr = imem_data;
        live_s        = !reset && !redirect_valid;
        flush_s       = redirect_valid && !reset;
        q_empty_s     = (count_s == CNT_ZERO);
`ifdef FETCH_BYPASS_EN
        bypass_s      = live_s && q_empty_s;
`else
        bypass_s      = 1'b0;
`endif
        out_valid_s   = live_s && (!q_empty_s || bypass_s);
        if (bypass_s) begin
            out_entry_s = fetch_s;
        end else if (out_valid_s) begin
            out_entry_s = head_s;
        end else begin
            out_entry_s = fetch_entry_t'(64'h0);
        end
        q_pop_s = out_valid_s && out_ready && !bypass_s;
        // A full queue still accepts a fetch when its head leaves this cycle.
        room_s  = (count_s != CNT_FULL) || q_pop_s;
        if (bypass_s) begin
            advance_s = 1'b1;
            push_s    = !out_ready;
        end else begin
            advance_s = live_s && room_s;
            push_s    = advance_s;
        end
        if (reset) begin
            pc_d = RESET_PC;
        end else if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (advance_s) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_s),
        .push      (push_s),
        .push_data (fetch_s),
        .pop       (q_pop_s),
        .head_data (head_s),
        .count     (count_s)
    );

    assign imem_addr = pc_q;
    assign out_valid = out_valid_s;
    assign out_pc    = out_entry_s.pc;
    assign out_instr = out_entry_s.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference model predicts fetches into a scoreboard queue.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int n_tests;
    int n_fail;

    fetch_entry_t sb[$];
    logic [31:0]  m_pc;
    logic         m_known;

    fetch_unit #(
        .FQ_DEPTH (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // Combinational instruction memory: word i holds 32'h1000_0000 + i.
    assign imem_data = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic         exp_v;
        logic         byp;
        fetch_entry_t exp_e;
        fetch_entry_t fe;
        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        exp_v = 1'b0;
        byp   = 1'b0;
        exp_e = fetch_entry_t'(64'h0);
        fe.pc    = m_pc;
        fe.instr = mem_word(m_pc);
        if (!rst && m_known) begin
            check_eq("imem_addr", {32'h0, imem_addr}, {32'h0, m_pc});
        end
        if (!rst && !rv) begin
            if (sb.size() != 0) begin
                exp_v = 1'b1;
                exp_e = sb[0];
            end
`ifdef FETCH_BYPASS_EN
            else begin
                exp_v = 1'b1;
                exp_e = fe;
                byp   = 1'b1;
            end
`endif
        end
        check_eq("out_valid", {63'h0, out_valid}, {63'h0, exp_v});
        check_eq("out_entry", {out_pc, out_instr}, {exp_e.pc, exp_e.instr});
        if (rst) begin
            sb.delete();
            m_pc    = RST_PC;
            m_known = 1'b1;
        end else if (rv) begin
            sb.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else if (byp) begin
            if (!rdy) sb.push_back(fe);
            m_pc = m_pc + 32'd4;
        end else begin
            if (exp_v && rdy) void'(sb.pop_front());
            if (sb.size() < DEPTH) begin
                sb.push_back(fe);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        m_pc           = 32'h0;
        m_known        = 1'b0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        // Reset, then stream with decode always ready.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0080, 1'b1);
        check_eq("reset_pc", {32'h0, imem_addr}, {32'h0, RST_PC});
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Back-pressure: queue fills to DEPTH and pc holds at 16.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("hold_pc", {32'h0, imem_addr}, {32'h0, 32'd16});
        check_eq("full_cnt", 64'(sb.size()), 64'(DEPTH));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with a full queue: unaligned target, stale entries dropped.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0043, 1'b1);
        check_eq("redir_pc", {32'h0, imem_addr}, {32'h0, 32'h0000_0040});
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect together with a ready handshake on a non-empty queue.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-stream with three queued entries.
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("three_cnt", 64'(sb.size()), 64'd3);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("mid_reset_pc", {32'h0, imem_addr}, {32'h0, RST_PC});
        step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
        check_eq("wrap_top", {32'h0, imem_addr}, {32'h0, 32'hFFFF_FFFC});
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("wrap_zero", {32'h0, imem_addr}, {32'h0, 32'h0});
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Random ready and occasional redirects.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, ($urandom_range(0, 15) == 0), $urandom(), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
